pll_phase_scheduler: RTL and testbench
======================================

# pll_phase_scheduler

Shares the PLL dynamic-phase-shift and clock-switch control pins among several requesters: ADC capture calibration, host command decoder and the LVDS deskew loop. It arbitrates round-robin, sequences each phase step (select, direction, phasestep, scanclk toggling, phasedone wait) and issues clkswitch pulses. It sits between the command/calibration logic and the PLL reconfiguration ports.

## Interface
- NREQ, 2: number of phase-step requesters
- SCAN_DIV, 16: clk cycles per scanclk half-period (min 2)
- PS_TOGGLES, 6: scanclk toggles while phasestep is held high
- STEP_TOGGLES, 8: total scanclk toggles per step (even, > PS_TOGGLES)
- CLKSW_CYCLES, 8: clkswitch high time in clk cycles
- DONE_TIMEOUT, 1023: max clk cycles to wait for phasedone per step

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  request pending; held until req_ready
- req_sel  in  3*NREQ  counter select per requester (000 all, 001 M, 010..110 C0..C4)
- req_up  in  NREQ  1 = shift up, 0 = down
- req_steps  in  8*NREQ  number of steps; 0 = no-op
- req_ready  out  NREQ  one-cycle grant/accept pulse
- req_done  out  NREQ  one-cycle completion pulse
- req_err  out  NREQ  pulses with req_done on timeout abort
- clkswitch_req  in  1  single-cycle request to toggle PLL input clock
- phasedone  in  1  PLL phasedone (low while shifting), asynchronous; 2-flop synchronized
- phasecounterselect  out  3  to PLL
- phaseupdown  out  1  to PLL
- phasestep  out  1  to PLL
- scanclk  out  1  to PLL
- clkswitch  out  1  to PLL
- busy  out  1  high in any state but IDLE

## Operation
- States: IDLE, CLKSW, LOAD, STEP, WAIT_LO, WAIT_HI, NEXT, FINISH.
- clkswitch_req sets a sticky pending flag, accepted in any state and cleared on entering CLKSW.
- IDLE: if pending, go to CLKSW. Otherwise grant the round-robin winner among req_valid: pulse req_ready, latch sel/up/steps and go to LOAD. The RR pointer moves to winner+1.
- CLKSW: clkswitch=1 for CLKSW_CYCLES cycles, then 0, then IDLE.
- LOAD: drive phasecounterselect/phaseupdown from the latch; these stay stable until FINISH. If steps==0, go to FINISH. Otherwise set scanclk=0, phasestep=1 and go to STEP.
- STEP: scanclk toggles every SCAN_DIV cycles. phasestep drops on the same edge as toggle PS_TOGGLES. After toggle STEP_TOGGLES (scanclk back at 0), go to WAIT_LO.
- WAIT_LO: wait for synced phasedone==0. WAIT_HI: wait for synced phasedone==1. A single timeout counter covers both and is cleared at WAIT_LO entry. On expiry, set err and go to FINISH, dropping the remaining steps.
- NEXT: steps-1. If the result is nonzero, set phasestep=1 and scanclk=0 and go to STEP. Otherwise go to FINISH.
- FINISH: pulse req_done (plus req_err if err) to the owner, then go to IDLE. A clkswitch request pending during a transaction is serviced afterwards and never preempts it.
- Reset values: phasecounterselect=000, phaseupdown=1, phasestep=0, scanclk=0, clkswitch=0, req_ready/done/err=0, busy=0, RR pointer=0, pending=0.
- Reset mid-transaction: outputs go to reset values on the reset edge. The in-flight request is dropped silently, with no done pulse.

## Timing
- Grant latency: req_ready is high the cycle after req_valid is seen in IDLE. phasestep rises one cycle after req_ready.
- Per step: STEP_TOGGLES*SCAN_DIV cycles of scanclk activity, plus the phasedone wait, plus 1 cycle in NEXT.
- Simultaneous clkswitch_req and req_valid in IDLE: clkswitch goes first.
- A requester that drops req_valid before req_ready forfeits its slot. Inputs are sampled only at grant.

## Structure
- Package pll_sched_pkg holds the state enum, the counter-select constants (SEL_ALL, SEL_M, SEL_C0..SEL_C4) and the default parameter values.
- Sub-module rr_arbiter (NREQ-wide, one-hot grant, pointer update on accept). The scanclk divider stays inline.

## Test plan
- SCAN_DIV=4, req0 sel=011, up=1, steps=2, phasedone model low for 10 cycles after each step:
  - 16 scanclk toggles total; phasestep high for 6 toggles per step.
  - phasecounterselect=011 throughout; one req_done[0], req_err=0.
- req0 and req1 valid together, repeated 4 times: grants alternate 0,1,0,1.
- clkswitch_req during req1 transaction: the transaction completes first, then clkswitch high exactly 8 cycles.
- phasedone stuck high, DONE_TIMEOUT=50, steps=3: abort after the first step; req_done and req_err pulse together; only 8 toggles seen.
- steps=0: req_ready, then req_done 2 cycles later; phasestep/scanclk never toggle.
- rst asserted mid-STEP: next cycle all outputs at reset values, no req_done; a new request afterwards is granted normally.

Source files
------------

// File: rtl/pll_phase_scheduler_pkg.sv
// pll_sched_pkg: state encoding, PLL counter-select codes and default parameters
package pll_sched_pkg;
    typedef enum logic [2:0] {IDLE, CLKSW, LOAD, STEP, WAIT_LO, WAIT_HI, NEXT, FINISH} state_t;
    localparam logic [2:0] SEL_ALL = 3'b000, SEL_M = 3'b001, SEL_C0 = 3'b010, SEL_C1 = 3'b011,
                           SEL_C2 = 3'b100, SEL_C3 = 3'b101, SEL_C4 = 3'b110;
    localparam int DEF_NREQ = 2, DEF_SCAN_DIV = 16, DEF_PS_TOGGLES = 6, DEF_STEP_TOGGLES = 8,
                   DEF_CLKSW_CYCLES = 8, DEF_DONE_TIMEOUT = 1023;
endpackage

// File: rtl/pll_phase_scheduler_if.sv
// pll_phase_scheduler_if: per-requester phase-step request/grant/completion bundle
interface pll_phase_scheduler_if import pll_sched_pkg::*; #(parameter int NREQ = DEF_NREQ);
    logic [NREQ-1:0]   req_valid, req_up, req_ready, req_done, req_err;
    logic [3*NREQ-1:0] req_sel;
    logic [8*NREQ-1:0] req_steps;
    modport master(output req_valid, req_sel, req_up, req_steps, input req_ready, req_done, req_err);
    modport slave(input req_valid, req_sel, req_up, req_steps, output req_ready, req_done, req_err);
endinterface

// File: rtl/pll_phase_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; pointer moves past the winner on accept
module rr_arbiter #(parameter int N = 2) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant
);
    localparam int PW = N > 1 ? $clog2(N) : 1;
    logic [PW-1:0] ptr;
    logic [N-1:0]  rot;
    int off, win;
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = 0;
        for (int i = N - 1; i >= 0; i--) if (rot[i]) off = i;
        win = (int'(ptr) + off) % N;
        grant = |req ? N'(1) << win : '0;
    end
    always_ff @(posedge clk)
        if (rst) ptr <= '0;
        else if (accept) ptr <= PW'((win + 1) % N);
endmodule

// File: rtl/pll_phase_scheduler.sv
// pll_phase_scheduler: shares PLL dynamic phase-shift and clkswitch pins among requesters
module pll_phase_scheduler import pll_sched_pkg::*; #(
    parameter int NREQ         = DEF_NREQ,
    parameter int SCAN_DIV     = DEF_SCAN_DIV,
    parameter int PS_TOGGLES   = DEF_PS_TOGGLES,
    parameter int STEP_TOGGLES = DEF_STEP_TOGGLES,
    parameter int CLKSW_CYCLES = DEF_CLKSW_CYCLES,
    parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    pll_phase_scheduler_if.slave  rq,
    input  logic                  clkswitch_req,
    input  logic                  phasedone,
    output logic [2:0]            phasecounterselect,
    output logic                  phaseupdown,
    output logic                  phasestep,
    output logic                  scanclk,
    output logic                  clkswitch,
    output logic                  busy
);
    localparam logic [15:0] DIV_L = 16'(SCAN_DIV - 1), TMO_L = 16'(DONE_TIMEOUT - 1), CSW_L = 16'(CLKSW_CYCLES - 1);
    localparam logic [7:0]  PS_L = 8'(PS_TOGGLES - 1), TOG_L = 8'(STEP_TOGGLES - 1);

    state_t          state, nxt;
    logic            pend, pd_m, pd_s, err, tick, tmo, accept, go_csw;
    logic [NREQ-1:0] grant, owner, ready_d, done_d, err_d;
    logic [2:0]      sel_q, g_sel, pcs_d;
    logic            up_q, g_up, pud_d, ps_d, sclk_d, csw_d;
    logic [7:0]      steps_q, g_steps, tog_cnt;
    logic [15:0]     cnt;

    rr_arbiter #(.N(NREQ)) u_arb (.clk(clk), .rst(rst), .req(rq.req_valid), .accept(accept), .grant(grant));

    assign go_csw = pend | clkswitch_req;
    assign accept = state == IDLE && !go_csw && |grant;
    assign tick   = state == STEP && cnt == DIV_L;
    assign tmo    = cnt == TMO_L;
    assign busy   = state != IDLE;

    always_comb begin
        g_sel = '0;
        g_up = 1'b0;
        g_steps = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                g_sel = rq.req_sel[3*i +: 3];
                g_up = rq.req_up[i];
                g_steps = rq.req_steps[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = go_csw ? CLKSW : accept ? LOAD : IDLE;
            CLKSW:   nxt = cnt == CSW_L ? IDLE : CLKSW;
            LOAD:    nxt = steps_q == 8'd0 ? FINISH : STEP;
            STEP:    nxt = tick && tog_cnt == TOG_L ? WAIT_LO : STEP;
            WAIT_LO: nxt = !pd_s ? WAIT_HI : tmo ? FINISH : WAIT_LO;
            WAIT_HI: nxt = pd_s ? NEXT : tmo ? FINISH : WAIT_HI;
            NEXT:    nxt = steps_q == 8'd1 ? FINISH : STEP;
            FINISH:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_d = accept ? grant : '0;
        done_d  = state == FINISH ? owner : '0;
        err_d   = state == FINISH && err ? owner : '0;
        pcs_d   = state == LOAD ? sel_q : phasecounterselect;
        pud_d   = state == LOAD ? up_q : phaseupdown;
        ps_d    = (state == LOAD && steps_q != 8'd0) || (state == NEXT && steps_q != 8'd1) ? 1'b1 :
                  tick && tog_cnt == PS_L ? 1'b0 : phasestep;
        sclk_d  = tick ? ~scanclk : state == LOAD || state == NEXT ? 1'b0 : scanclk;
        csw_d   = nxt == CLKSW;
    end

    // cnt is the scanclk divider in STEP, the phasedone timeout across both WAIT states, and the clkswitch width
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            pd_m <= 1'b1;
            pd_s <= 1'b1;
            err <= 1'b0;
            owner <= '0;
            sel_q <= '0;
            up_q <= 1'b1;
            steps_q <= '0;
            tog_cnt <= '0;
            cnt <= '0;
            rq.req_ready <= '0;
            rq.req_done <= '0;
            rq.req_err <= '0;
            phasecounterselect <= SEL_ALL;
            phaseupdown <= 1'b1;
            phasestep <= 1'b0;
            scanclk <= 1'b0;
            clkswitch <= 1'b0;
        end else begin
            pend <= state != IDLE && go_csw;
            pd_m <= phasedone;
            pd_s <= pd_m;
            cnt <= (nxt != state && state != WAIT_LO) || tick ? '0 : cnt + 16'd1;
            tog_cnt <= state != STEP ? '0 : tick ? tog_cnt + 8'd1 : tog_cnt;
            if (accept) begin
                sel_q <= g_sel;
                up_q <= g_up;
                steps_q <= g_steps;
                owner <= grant;
                err <= 1'b0;
            end
            if (state == NEXT) steps_q <= steps_q - 8'd1;
            if ((state == WAIT_LO || state == WAIT_HI) && nxt == FINISH) err <= 1'b1;
            rq.req_ready <= ready_d;
            rq.req_done <= done_d;
            rq.req_err <= err_d;
            phasecounterselect <= pcs_d;
            phaseupdown <= pud_d;
            phasestep <= ps_d;
            scanclk <= sclk_d;
            clkswitch <= csw_d;
        end
    end
endmodule

// File: tb/tb_pll_phase_scheduler.sv
// tb_pll_phase_scheduler: scoreboard bench with a simple PLL phasedone model
module tb_pll_phase_scheduler;
    import pll_sched_pkg::*;
    localparam int SCAN_DIV = 4, PS_T = 6, STEP_T = 8, CSW_N = 8, TMO = 50;

    typedef struct {int who; int err; int tog; int ps; int rise; int sel; int up; int lat;} exp_t;

    logic clk = 0, rst = 1, clkswitch_req = 0, phasedone;
    logic [2:0] phasecounterselect;
    logic phaseupdown, phasestep, scanclk, clkswitch, busy;
    bit stuck_hi = 0;
    int n_cmp = 0, n_bad = 0, ptr = 0;
    int gnt_q[$], csw_q[$];
    exp_t done_q[$];

    pll_phase_scheduler_if #(.NREQ(2)) bus ();

    pll_phase_scheduler #(.NREQ(2), .SCAN_DIV(SCAN_DIV), .PS_TOGGLES(PS_T), .STEP_TOGGLES(STEP_T),
                          .CLKSW_CYCLES(CSW_N), .DONE_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .rq(bus), .clkswitch_req(clkswitch_req), .phasedone(phasedone),
        .phasecounterselect(phasecounterselect), .phaseupdown(phaseupdown), .phasestep(phasestep),
        .scanclk(scanclk), .clkswitch(clkswitch), .busy(busy));

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    // PLL model: phasedone dips low for 10 cycles starting 8 cycles after phasestep falls
    int pd_t = 0;
    logic ps_q = 0;
    always @(negedge clk) begin
        ps_q <= phasestep;
        pd_t <= ps_q && !phasestep ? 18 : pd_t > 0 ? pd_t - 1 : 0;
    end
    assign phasedone = stuck_hi || !(pd_t > 0 && pd_t <= 10);

    logic sc_prev = 0, ps_prev = 0, csw_prev = 0;
    int tog = 0, ps_tog = 0, rise = 0, csw_len = 0, cyc = 0, rdy_cyc = 0;
    bit inflight = 0;
    exp_t e;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            inflight = 0; sc_prev = 0; ps_prev = 0; csw_prev = 0; csw_len = 0;
        end else begin
            if (scanclk != sc_prev) begin
                tog++;
                if (ps_prev) ps_tog++;
            end
            if (phasestep && !ps_prev) rise++;
            if (|bus.req_ready) begin
                check("ready_onehot", $countones(bus.req_ready), 1);
                check("csw_before_grant", csw_q.size(), 0);
                if (gnt_q.size() == 0) check("ready_unexpected", bus.req_ready, 0);
                else check("grant_idx", bus.req_ready[1] ? 1 : 0, gnt_q.pop_front());
                tog = 0; ps_tog = 0; rise = 0; inflight = 1; rdy_cyc = cyc;
            end
            if (|bus.req_done) begin
                if (done_q.size() == 0) check("done_unexpected", bus.req_done, 0);
                else begin
                    e = done_q.pop_front();
                    check("done_idx", bus.req_done, 1 << e.who);
                    check("err_vec", bus.req_err, e.err ? bus.req_done : 2'b00);
                    check("toggles", tog, e.tog);
                    check("ps_toggles", ps_tog, e.ps);
                    check("ps_rises", rise, e.rise);
                    check("sel", phasecounterselect, e.sel);
                    check("updown", phaseupdown, e.up);
                    if (e.lat >= 0) check("done_latency", cyc - rdy_cyc, e.lat);
                end
                inflight = 0;
            end else if (|bus.req_err) check("err_without_done", bus.req_err, 0);
            if (clkswitch) csw_len++;
            if (clkswitch && !csw_prev) check("csw_no_txn", inflight, 0);
            if (!clkswitch && csw_prev) begin
                if (csw_q.size() == 0) check("csw_unexpected", csw_len, 0);
                else check("csw_len", csw_len, csw_q.pop_front());
                csw_len = 0;
            end
            sc_prev = scanclk; ps_prev = phasestep; csw_prev = clkswitch;
        end
    end

    function automatic exp_t mk(input int r, input int st, input bit to);
        exp_t x;
        int n = to ? (st > 0 ? 1 : 0) : st;
        x.who = r; x.err = to && st > 0; x.tog = STEP_T * n; x.ps = PS_T * n; x.rise = n;
        x.sel = r == 0 ? SEL_C1 : SEL_C3; x.up = r == 0; x.lat = st == 0 ? 2 : -1;
        return x;
    endfunction

    task automatic expect_req(input int r, input int st, input bit to);
        gnt_q.push_back(r);
        done_q.push_back(mk(r, st, to));
        ptr = (r + 1) % 2;
    endtask

    task automatic run(input logic [1:0] mask, input int steps, input bit to, input int csw_at);
        bit ok = 0;
        if (mask == 2'b11) begin
            int first = ptr;
            expect_req(first, steps, to);
            expect_req(1 - first, steps, to);
        end else expect_req(mask[1] ? 1 : 0, steps, to);
        bus.req_sel = {SEL_C3, SEL_C1};
        bus.req_up = 2'b01;
        bus.req_steps = {8'(steps), 8'(steps)};
        bus.req_valid = mask;
        for (int n = 0; n < 3000; n++) begin
            if (n == csw_at) begin
                clkswitch_req = 1;
                csw_q.push_back(CSW_N);
            end
            @(negedge clk);
            clkswitch_req = 0;
            bus.req_valid = bus.req_valid & ~bus.req_ready;
            if (bus.req_valid == 0 && done_q.size() == 0 && csw_q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        check("run_complete", ok, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_pcs", phasecounterselect, 0);
        check("rst_updown", phaseupdown, 1);
        check("rst_phasestep", phasestep, 0);
        check("rst_scanclk", scanclk, 0);
        check("rst_clkswitch", clkswitch, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", bus.req_ready, 0);
        check("rst_done", bus.req_done, 0);
        check("rst_err", bus.req_err, 0);
    endtask

    initial begin
        bit got;
        bus.req_valid = 0; bus.req_sel = 0; bus.req_up = 0; bus.req_steps = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 0;
        repeat (2) @(negedge clk);
        repeat (4) run(2'b11, 1, 0, -1);
        run(2'b01, 2, 0, -1);
        run(2'b10, 1, 0, 10);
        run(2'b01, 1, 0, 0);
        stuck_hi = 1;
        run(2'b01, 3, 1, -1);
        stuck_hi = 0;
        run(2'b10, 0, 0, -1);
        gnt_q.push_back(0);
        bus.req_steps = {8'd2, 8'd2};
        bus.req_valid = 2'b01;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = bus.req_ready[0];
        end
        check("rst_test_grant", got, 1);
        bus.req_valid = 0;
        repeat (10) @(negedge clk);
        check("midstep_phasestep", phasestep, 1);
        rst = 1;
        @(negedge clk);
        check_reset_outputs();
        rst = 0;
        ptr = 0;
        repeat (60) @(negedge clk);
        check("no_done_after_rst_busy", busy, 0);
        run(2'b11, 1, 0, -1);
        check("gnt_q_empty", gnt_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        check("csw_q_empty", csw_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
